// File: rtl/risc_multicycle_param.sv
// risc_multicycle_param
//   Multicycle RISC core: control FSM, 8-entry register file (r0 reads 0),
//   ALU and PC logic. DW-bit data, AW-bit word addresses, and a req/ready
//   handshake to a unified external memory that may insert wait states.
// Ports:
//   clk, reset (async, active low)
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, held until ready
//   mem_rdata/mem_ready               : read data and transfer complete
//   halted, illegal, retire           : status, illegal/retire are pulses
//   instr_count                       : retired instruction counter (wraps)
//   dbg_pc                            : current PC
module risc_multicycle_param #(
  parameter int            DW       = 16,
  parameter int            AW       = 6,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          halted,
  output logic          illegal,
  output logic          retire,
  output logic [31:0]   instr_count,
  output logic [AW-1:0] dbg_pc
);
  localparam int SHW = $clog2(DW);

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JAL  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg;
  logic [15:0]   ir_reg;
  logic [DW-1:0] a_reg, b_reg, alu_reg;
  logic [31:0]   count_reg;
  logic [DW-1:0] rf_reg [0:7];

  // Instruction fields
  logic [2:0] op, rd, rs1, rs2;
  logic [3:0] func;
  assign op   = ir_reg[15:13];
  assign rd   = ir_reg[12:10];
  assign rs1  = ir_reg[9:7];
  assign rs2  = ir_reg[6:4];
  assign func = ir_reg[3:0];

  // Sign-extended immediates; the jump offset only ever feeds the PC adder.
  logic [DW-1:0] imm_i, imm_s;
  logic [AW-1:0] off_j;
  assign imm_i = DW'($signed(ir_reg[6:0]));
  assign imm_s = DW'($signed({ir_reg[12:10], ir_reg[3:0]}));
  assign off_j = AW'($signed(ir_reg[9:0]));

  logic is_illegal;
  assign is_illegal = (op == 3'b110) || ((op == OP_R) && func[3]);

  // ALU, evaluated from the operands latched in DECODE
  logic [DW-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (op)
      OP_R: begin
        case (func)
          4'd0:    alu_res = a_reg + b_reg;
          4'd1:    alu_res = a_reg - b_reg;
          4'd2:    alu_res = a_reg & b_reg;
          4'd3:    alu_res = a_reg | b_reg;
          4'd4:    alu_res = a_reg ^ b_reg;
          4'd5:    alu_res = a_reg << b_reg[SHW-1:0];
          4'd6:    alu_res = a_reg >> b_reg[SHW-1:0];
          4'd7:    alu_res = ($signed(a_reg) < $signed(b_reg)) ? DW'(1) : '0;
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW: alu_res = a_reg + imm_i;
      OP_SW:          alu_res = a_reg + imm_s;
      default:        alu_res = '0;
    endcase
  end

  // Control FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_BOOT;
    else        state_reg <= state_next;
  end

  // Control FSM: next state and outputs
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc_reg;
    retire     = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_BOOT:   state_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (is_illegal) begin
          illegal    = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          case (op)
            OP_R, OP_ADDI: state_next = S_WB;
            OP_LW, OP_SW:  state_next = S_MEM;
            OP_HALT: begin
              retire     = 1'b1;
              state_next = S_HALTED;
            end
            default: begin // BEQ, JAL
              retire     = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_reg[AW-1:0];
        mem_we   = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_SW) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: halted = 1'b1;
      default:  state_next = S_BOOT;
    endcase
  end

  // Register write port: WB writes ALUout (or load data), JAL writes PCn in EXEC.
  logic          wb_en;
  logic [DW-1:0] wb_data;
  assign wb_en   = (state_reg == S_WB) || ((state_reg == S_EXEC) && (op == OP_JAL));
  assign wb_data = (state_reg == S_EXEC) ? DW'(pc_reg) : alu_reg;

  // Entry 0 is never written, so it holds its reset value of zero.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rf
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          rf_reg[gi] <= '0;
        else if (wb_en && (gi != 0) && (rd == 3'(gi)))
          rf_reg[gi] <= wb_data;
      end
    end
  endgenerate

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      alu_reg   <= '0;
      count_reg <= '0;
    end else begin
      if ((state_reg == S_FETCH) && mem_ready) begin
        ir_reg <= mem_rdata[15:0];
        pc_reg <= pc_reg + AW'(1);
      end
      if (state_reg == S_DECODE) begin
        a_reg <= rf_reg[rs1];
        b_reg <= rf_reg[rs2];
      end
      if (state_reg == S_EXEC) begin
        alu_reg <= alu_res;
        // pc_reg already holds PCn here
        if ((op == OP_BEQ) && (a_reg == b_reg)) pc_reg <= pc_reg + imm_s[AW-1:0];
        if (op == OP_JAL)                       pc_reg <= pc_reg + off_j;
      end
      if ((state_reg == S_MEM) && mem_ready && (op == OP_LW))
        alu_reg <= mem_rdata;
      if (retire)
        count_reg <= count_reg + 32'd1;
    end
  end

  assign mem_wdata   = b_reg;
  assign instr_count = count_reg;
  assign dbg_pc      = pc_reg;

endmodule

// File: tb/tb_risc_multicycle_param.sv
// Scoreboard bench for risc_multicycle_param: a memory model with optional
// wait states checks every bus transfer and every retire interval against
// queues filled while each program is loaded.
module tb_risc_multicycle_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset2;
  logic        mem_req, mem_we, mem_ready, halted, illegal, retire;
  logic [5:0]  mem_addr, dbg_pc;
  logic [15:0] mem_wdata, mem_rdata;
  logic [31:0] instr_count;
  logic        mem_req2, mem_we2, mem_ready2, halted2, illegal2, retire2;
  logic [3:0]  mem_addr2, dbg_pc2;
  logic [15:0] mem_wdata2, mem_rdata2;
  logic [31:0] instr_count2;

  risc_multicycle_param #(.DW(16), .AW(6), .RESET_PC(6'd0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .illegal(illegal),
    .retire(retire), .instr_count(instr_count), .dbg_pc(dbg_pc));

  risc_multicycle_param #(.DW(16), .AW(4), .RESET_PC(4'd15)) dut2 (
    .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .mem_ready(mem_ready2), .halted(halted2), .illegal(illegal2),
    .retire(retire2), .instr_count(instr_count2), .dbg_pc(dbg_pc2));

  typedef struct {bit we; int unsigned addr; int unsigned data;} txn_t;
  txn_t exp_q[$], exp2_q[$];
  int   lat_q[$];

  logic [15:0] mem  [0:63];
  logic [15:0] mem2 [0:15];
  int n_cmp = 0, n_err = 0;
  int cycle = 0, last_ret = 0, ill_cnt = 0, wait_st = 0, wcnt = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [15:0] f_r(int rd, int rs1, int rs2, int fn);
    return {3'b000, 3'(rd), 3'(rs1), 3'(rs2), 4'(fn)};
  endfunction
  function automatic logic [15:0] f_i(int op, int rd, int rs1, int imm);
    return {3'(op), 3'(rd), 3'(rs1), 7'(imm)};
  endfunction
  function automatic logic [15:0] f_s(int op, int rs1, int rs2, int imm);
    logic [6:0] v;
    v = 7'(imm);
    return {3'(op), v[6:4], 3'(rs1), 3'(rs2), v[3:0]};
  endfunction
  function automatic logic [15:0] f_j(int rd, int imm);
    return {3'b101, 3'(rd), 10'(imm)};
  endfunction
  localparam logic [15:0] HALT = 16'hE000;

  task automatic ef(input int a);
    txn_t t; t.we = 0; t.addr = a; t.data = 0; exp_q.push_back(t);
  endtask
  task automatic ew(input int a, input int d);
    txn_t t; t.we = 1; t.addr = a; t.data = d; exp_q.push_back(t);
  endtask
  // Place a word, expect its fetch, an optional store, and its retire interval.
  task automatic instr(input int pc, input logic [15:0] w, input int lat,
                       input int st_addr = -1, input int st_data = 0);
    mem[pc] = w;
    ef(pc);
    if (st_addr >= 0) ew(st_addr, st_data);
    lat_q.push_back(lat);
  endtask

  task automatic clr();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  task automatic bus1(input bit we, input int unsigned a, input int unsigned d);
    txn_t e;
    $display("txn core  %s addr=%0d data=0x%04h", we ? "WR" : "RD", a, d);
    if (exp_q.size() == 0) begin
      check("txn_extra", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("txn_we", we, e.we);
      check("txn_addr", a, e.addr);
      if (e.we) check("txn_wdata", d, e.data);
    end
  endtask

  task automatic bus2(input bit we, input int unsigned a, input int unsigned d);
    txn_t e;
    $display("txn core2 %s addr=%0d data=0x%04h", we ? "WR" : "RD", a, d);
    if (exp2_q.size() == 0) begin
      check("txn2_extra", 1, 0);
    end else begin
      e = exp2_q.pop_front();
      check("txn2_we", we, e.we);
      check("txn2_addr", a, e.addr);
      if (e.we) check("txn2_wdata", d, e.data);
    end
  endtask

  // Memory models and retire monitor
  initial begin
    mem_ready = 1'b0; mem_rdata = '0; mem_ready2 = 1'b0; mem_rdata2 = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (mem_req) begin
        if (wcnt >= wait_st) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
          wcnt = 0;
          bus1(mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata);
          if (mem_we) mem[mem_addr] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b1; // ignored while no request is pending
        wcnt = 0;
      end
      mem_ready2 = 1'b1;
      mem_rdata2 = mem2[mem_addr2];
      if (mem_req2) begin
        bus2(mem_we2, mem_addr2, mem_we2 ? mem_wdata2 : mem_rdata2);
        if (mem_we2) mem2[mem_addr2] = mem_wdata2;
      end
      #1;
      if (retire) begin
        if (lat_q.size() == 0) check("retire_extra", 1, 0);
        else check("retire_cycles", cycle - last_ret, lat_q.pop_front());
        last_ret = cycle;
      end
      if (illegal) ill_cnt++;
    end
  end

  task automatic run_phase(input int ws, input int exp_cnt, input int exp_ill);
    bit ok;
    wait_st = ws;
    reset = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
    last_ret = cycle;
    ill_cnt = 0;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #2;
      if (halted) begin ok = 1; break; end
    end
    check("halt_seen", ok, 1);
    repeat (3) begin
      @(negedge clk); #2;
      check("halted_req", mem_req, 0);
      check("halted_flag", halted, 1);
    end
    check("instr_count", instr_count, exp_cnt);
    check("illegal_pulses", ill_cnt, exp_ill);
    check("txn_left", exp_q.size(), 0);
    check("retire_left", lat_q.size(), 0);
    exp_q.delete();
    lat_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0; reset2 = 1'b0;
    clr();
    for (int i = 0; i < 16; i++) mem2[i] = 16'h0000;
    repeat (2) @(negedge clk); #2;

    // Reset state
    check("rst_req", mem_req, 0);     check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);   check("rst_wdata", mem_wdata, 0);
    check("rst_halted", halted, 0);   check("rst_illegal", illegal, 0);
    check("rst_retire", retire, 0);   check("rst_count", instr_count, 0);
    check("rst_pc", dbg_pc, 0);
    check("rst2_addr", mem_addr2, 15); check("rst2_pc", dbg_pc2, 15);
    check("rst2_req", mem_req2, 0);

    // ALU sequence, zero wait states
    clr();
    instr(0,  f_i(1, 1, 0, 5), 4);
    instr(1,  f_i(1, 2, 0, -3), 4);
    instr(2,  f_r(3, 1, 2, 0), 4);
    instr(3,  f_r(4, 2, 1, 7), 4);
    instr(4,  f_s(3, 0, 3, 40), 4, 40, 2);
    instr(5,  f_s(3, 0, 4, 41), 4, 41, 1);
    instr(6,  f_r(5, 1, 2, 5), 4);
    instr(7,  f_r(6, 2, 1, 6), 4);
    instr(8,  f_s(3, 0, 5, 42), 4, 42, 16'hA000);
    instr(9,  f_s(3, 0, 6, 43), 4, 43, 16'h07FF);
    instr(10, f_r(3, 1, 2, 1), 4);
    instr(11, f_r(4, 1, 2, 3), 4);
    instr(12, f_r(5, 1, 2, 4), 4);
    instr(13, f_r(6, 2, 3, 2), 4);
    instr(14, f_s(3, 0, 3, 44), 4, 44, 8);
    instr(15, f_s(3, 0, 4, 45), 4, 45, 16'hFFFD);
    instr(16, f_s(3, 0, 5, 46), 4, 46, 16'hFFF8);
    instr(17, f_s(3, 0, 6, 47), 4, 47, 8);
    instr(18, f_r(7, 1, 2, 7), 4);
    instr(19, f_s(3, 0, 7, 48), 4, 48, 0);
    instr(20, HALT, 3);
    run_phase(0, 21, 0);

    // Load/store with two wait cycles per request
    clr();
    instr(0, f_i(1, 1, 0, 18), 6);
    instr(1, f_i(1, 2, 0, 8), 6);
    instr(2, f_r(1, 1, 2, 5), 6);
    instr(3, f_i(1, 1, 1, 52), 6);
    instr(4, f_s(3, 0, 1, 10), 8, 10, 16'h1234);
    mem[5] = f_i(2, 5, 0, 10); ef(5); ef(10); lat_q.push_back(9);
    instr(6, f_s(3, 0, 5, 11), 8, 11, 16'h1234);
    instr(7, HALT, 5);
    run_phase(2, 8, 0);

    // Branch and jump, listed in execution order
    clr();
    instr(0,  f_s(4, 6, 0, 1), 3);
    instr(2,  f_i(1, 1, 0, 9), 4);
    instr(3,  f_i(1, 2, 0, 9), 4);
    instr(4,  f_s(4, 1, 2, 2), 3);
    mem[5] = HALT; mem[6] = HALT;
    instr(7,  f_j(6, -8), 3);
    instr(0,  f_s(4, 6, 0, 1), 3);
    instr(1,  f_j(0, 8), 3);
    instr(10, f_s(3, 0, 6, 40), 4, 40, 8);
    instr(11, f_s(3, 0, 0, 41), 4, 41, 0);
    instr(12, HALT, 3);
    run_phase(0, 10, 0);

    // Illegal opcodes then halt
    clr();
    instr(0, f_i(1, 1, 0, 1), 4);
    instr(1, 16'hC000, 3);
    instr(2, f_r(1, 1, 1, 9), 3);
    instr(3, f_s(3, 0, 1, 40), 4, 40, 1);
    instr(4, HALT, 3);
    run_phase(0, 5, 2);

    // Reset while an LW is waiting in MEM
    clr();
    instr(0, f_i(1, 5, 0, 7), 6);
    mem[1] = f_i(2, 5, 0, 20); ef(1);
    mem[20] = 16'h5555;
    wait_st = 2;
    reset = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
    last_ret = cycle;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (mem_req && !mem_we && mem_addr == 6'd20) begin found = 1; break; end
    end
    check("lw_mem_seen", found, 1);
    #1 reset = 1'b0;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_count", instr_count, 0);
    check("abort_pc", dbg_pc, 0);
    check("abort_txn_left", exp_q.size(), 0);
    exp_q.delete(); lat_q.delete();
    clr();
    instr(0, f_s(3, 0, 5, 41), 8, 41, 0);
    instr(1, HALT, 5);
    run_phase(2, 2, 0);

    // PC wrap on the AW=4, RESET_PC=15 core
    begin
      txn_t t;
      mem2[15] = f_i(1, 1, 0, 3);
      mem2[0]  = f_s(3, 0, 1, 5);
      mem2[1]  = HALT;
      t.we = 0; t.addr = 15; t.data = 0; exp2_q.push_back(t);
      t.we = 0; t.addr = 0;  t.data = 0; exp2_q.push_back(t);
      t.we = 1; t.addr = 5;  t.data = 3; exp2_q.push_back(t);
      t.we = 0; t.addr = 1;  t.data = 0; exp2_q.push_back(t);
    end
    @(negedge clk); #2;
    reset2 = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (halted2) begin found = 1; break; end
    end
    check("halt2_seen", found, 1);
    @(negedge clk); #2;
    check("halt2_req", mem_req2, 0);
    check("count2", instr_count2, 3);
    check("pc2_final", dbg_pc2, 2);
    check("txn2_left", exp2_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
